// File: rtl/hex_display_pkg.sv
// Shared types and segment constants for the hex display scanner.
// Segment vectors are {a,b,c,d,e,f,g} with bit 6 = a, active low.
package hex_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_lut
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex display driver with frame-synchronous update,
// leading-zero suppression, decimal points and an anti-ghosting blank window.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYC     = 500,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] active;
    logic [N_DIGITS-1:0]   active_dp;
    logic [4*N_DIGITS-1:0] pend_value;
    logic [N_DIGITS-1:0]   pend_dp;
    logic                  pend_valid;
    logic                  wrapped;

    logic                  frame_end;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic [N_DIGITS-1:0]   sel;
    logic                  zero_run;
    logic                  suppress;
    logic                  in_blank;
    logic [6:0]            lut_seg;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [N_DIGITS-1:0]   an_next;

    assign frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);
    assign in_blank  = int'(cnt) < BLANK_CYC;

    // Digit mux plus suppression: walk down from the top digit while the
    // nibbles stay zero; the selected digit is blanked if it lies in that run.
    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        sel      = '0;
        zero_run = 1'b1;
        suppress = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = active[4*i +: 4];
                cur_dp  = active_dp[i];
                sel[i]  = 1'b1;
            end
        end
        for (int unsigned i = N_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (active[4*i +: 4] == 4'h0);
            if ((idx == IDX_W'(i)) && zero_run) begin
                suppress = lz_en;
            end
        end
    end

    seg7_hex_lut u_lut (
        .nibble (cur_nib),
        .seg    (lut_seg)
    );

    always_comb begin
        seg_next = suppress ? SEG_BLANK : lut_seg;
        dp_next  = ~(cur_dp & ~suppress);
        if (in_blank) begin
            an_next = AN_OFF;
        end else begin
            an_next = (AN_ACTIVE_LOW != 0) ? ~sel : sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load on the frame-end cycle bypasses pending so it lands in the very next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= '0;
            active_dp  <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (frame_end) begin
            if (load) begin
                active    <= value;
                active_dp <= dp_in;
            end else if (pend_valid) begin
                active    <= pend_value;
                active_dp <= pend_dp;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_value <= value;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
            an         <= AN_OFF;
            wrapped    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp_n       <= dp_next;
            an         <= an_next;
            wrapped    <= frame_end;
            frame_tick <= wrapped;
        end
    end

endmodule
